// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Sequences the four pipeline stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   and the PC register. It detects load-use hazards, branch mispredicts and
//   data-memory wait stalls. A small FSM tracks the memory wait and enters a
//   sticky FAULT state if the memory never answers. It also keeps saturating
//   performance counters for stall cycles and mispredict flushes.
//
// Ports:
//   stg_clk                  pipeline clock; all state updates on its rising edge
//   reset                    synchronous, active-high
//   id_valid, id_rs1/2,
//   id_rs1_used/id_rs2_used  instruction in decode and the sources it reads
//   ex_valid, ex_rd,
//   ex_rd_memory             instruction in execute, its destination, is-load
//   ex_is_branch,
//   ex_mispredict            branch in execute resolved against its prediction
//   mem_req, mem_ready       data-memory access in progress / completes now
//   pc_ena, pc_redirect      PC load enable / select resolved branch target
//   if/id/ex/mem _ena, _x    per-latch enable and flush
//   state                    00 RUN, 01 MEM_WAIT, 10 FAULT
//   mem_timeout              sticky memory-timeout flag (set on entering FAULT)
//   stall_cycles             saturating count of stall cycles
//   flush_count              saturating count of mispredict flushes
//
// The latch controls are combinational from the current state and inputs.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             stg_clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             ex_valid,
   input  logic [4:0]       ex_rd,
   input  logic             ex_rd_memory,
   input  logic             ex_is_branch,
   input  logic             ex_mispredict,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_ena,
   output logic             pc_redirect,
   output logic             if_ena,
   output logic             if_x,
   output logic             id_ena,
   output logic             id_x,
   output logic             ex_ena,
   output logic             ex_x,
   output logic             mem_ena,
   output logic             mem_x,
   output logic [1:0]       state,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   // Wide enough to hold MEM_TIMEOUT itself.
   localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_FAULT    = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0]  flush_count_q, flush_count_d;

   logic mem_stall;
   logic mispred;
   logic load_use;
   logic in_fault;

   // Hazard terms
   always_comb begin
      mem_stall = mem_req & ~mem_ready;
      mispred   = ex_valid & ex_is_branch & ex_mispredict;
      load_use  = ex_valid & ex_rd_memory & (ex_rd != 5'd0) & id_valid
                & ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
      in_fault  = (state_q == ST_FAULT);
   end

   // Latch controls. Priority: fault > mem_stall > mispred > load_use > normal.
   always_comb begin
      pc_ena      = 1'b0;
      pc_redirect = 1'b0;
      if_ena      = 1'b0;
      if_x        = 1'b0;
      id_ena      = 1'b0;
      id_x        = 1'b0;
      ex_ena      = 1'b0;
      ex_x        = 1'b0;
      mem_ena     = 1'b0;
      mem_x       = 1'b0;
      if (reset) begin
         // Everything held and nothing flushed while in reset.
      end else if (in_fault || mem_stall) begin
         // Freeze the pipe; feed a bubble into WB so the instruction in MEM
         // is not written back a second time.
         mem_x = 1'b1;
      end else if (mispred) begin
         // Squash the two younger instructions; load-use is irrelevant since
         // the dependent instruction is among those squashed.
         pc_ena      = 1'b1;
         pc_redirect = 1'b1;
         if_x        = 1'b1;
         id_x        = 1'b1;
         ex_ena      = 1'b1;
         mem_ena     = 1'b1;
      end else if (load_use) begin
         // Hold PC and IF/ID; insert a bubble into ID/EX.
         id_x    = 1'b1;
         ex_ena  = 1'b1;
         mem_ena = 1'b1;
      end else begin
         pc_ena  = 1'b1;
         if_ena  = 1'b1;
         id_ena  = 1'b1;
         ex_ena  = 1'b1;
         mem_ena = 1'b1;
      end
   end

   // Memory-wait FSM. wait_cnt counts consecutive stall cycles seen so far;
   // the edge ending stall number MEM_TIMEOUT enters FAULT.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      case (state_q)
         ST_RUN: begin
            if (mem_stall) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            if (mem_stall) begin
               if (wait_cnt_q == WAIT_LAST) begin
                  state_d       = ST_FAULT;
                  mem_timeout_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end else begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end
         end
         ST_FAULT: begin
            // Held until reset.
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Saturating performance counters, frozen in FAULT.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (!in_fault) begin
         if ((mem_stall || (!mispred && load_use)) && (stall_cycles_q != CNT_MAX))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
         if (!mem_stall && mispred && (flush_count_q != CNT_MAX))
            flush_count_d = flush_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge stg_clk) begin
      if (reset) begin
         state_q        <= ST_RUN;
         wait_cnt_q     <= '0;
         mem_timeout_q  <= 1'b0;
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         mem_timeout_q  <= mem_timeout_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign state        = state_q;
   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl with CNT_W=4 and MEM_TIMEOUT=4 so
// that both counter saturation and the memory timeout are reachable quickly.
// Latch controls are compared as a 10-bit vector:
//   {pc_ena, pc_redirect, if_ena, if_x, id_ena, id_x, ex_ena, ex_x, mem_ena, mem_x}
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 4;
   localparam int MEM_TIMEOUT = 4;

   localparam logic [9:0] ROW_OFF    = 10'b00_00_00_00_00;
   localparam logic [9:0] ROW_NORMAL = 10'b10_10_10_10_10;
   localparam logic [9:0] ROW_MSTALL = 10'b00_00_00_00_01;
   localparam logic [9:0] ROW_MISPR  = 10'b11_01_01_10_10;
   localparam logic [9:0] ROW_LDUSE  = 10'b00_00_01_10_10;

   logic             stg_clk = 1'b0;
   logic             reset;
   logic             id_valid;
   logic [4:0]       id_rs1, id_rs2;
   logic             id_rs1_used, id_rs2_used;
   logic             ex_valid;
   logic [4:0]       ex_rd;
   logic             ex_rd_memory, ex_is_branch, ex_mispredict;
   logic             mem_req, mem_ready;
   logic             pc_ena, pc_redirect, if_ena, if_x, id_ena, id_x;
   logic             ex_ena, ex_x, mem_ena, mem_x;
   logic [1:0]       state;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   int pass_cnt  = 0;
   int check_cnt = 0;

   always #5 stg_clk = ~stg_clk;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .stg_clk      (stg_clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_used  (id_rs1_used),
      .id_rs2_used  (id_rs2_used),
      .ex_valid     (ex_valid),
      .ex_rd        (ex_rd),
      .ex_rd_memory (ex_rd_memory),
      .ex_is_branch (ex_is_branch),
      .ex_mispredict(ex_mispredict),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .pc_ena       (pc_ena),
      .pc_redirect  (pc_redirect),
      .if_ena       (if_ena),
      .if_x         (if_x),
      .id_ena       (id_ena),
      .id_x         (id_x),
      .ex_ena       (ex_ena),
      .ex_x         (ex_x),
      .mem_ena      (mem_ena),
      .mem_x        (mem_x),
      .state        (state),
      .mem_timeout  (mem_timeout),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   wire [9:0] row = {pc_ena, pc_redirect, if_ena, if_x, id_ena, id_x,
                     ex_ena, ex_x, mem_ena, mem_x};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      $display("check %-16s observed %h expected %h", tag, obs, exp);
   endtask

   // Full registered-state check.
   task automatic check_regs(input string tag, input logic [1:0] st, input logic to,
                             input logic [CNT_W-1:0] sc, input logic [CNT_W-1:0] fc);
      check({tag, ".state"}, 32'(state), 32'(st));
      check({tag, ".tmo"},   32'(mem_timeout), 32'(to));
      check({tag, ".stall"}, 32'(stall_cycles), 32'(sc));
      check({tag, ".flush"}, 32'(flush_count), 32'(fc));
   endtask

   // Advance one edge; inputs are then changed 1 ns after it.
   task automatic tick();
      @(posedge stg_clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
      ex_valid = 1'b1; ex_rd = 5'd9; ex_rd_memory = 1'b0; ex_is_branch = 1'b0;
      ex_mispredict = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic set_load_use(input logic [4:0] r);
      ex_valid = 1'b1; ex_rd_memory = 1'b1; ex_rd = r;
      id_valid = 1'b1; id_rs1 = r; id_rs1_used = 1'b1;
   endtask

   task automatic set_mispred();
      ex_valid = 1'b1; ex_is_branch = 1'b1; ex_mispredict = 1'b1;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      // Hazards present during reset must not leak onto the controls.
      set_mispred();
      mem_req = 1'b1;
      tick();
      tick();
      #1 check("reset.row", 32'(row), 32'(ROW_OFF));
      check_regs("reset", 2'b00, 1'b0, 4'd0, 4'd0);

      // Normal flow
      reset = 1'b0;
      idle_inputs();
      #1 check("normal.row", 32'(row), 32'(ROW_NORMAL));
      tick();
      check_regs("normal", 2'b00, 1'b0, 4'd0, 4'd0);

      // Load-use on rs1 = x5: one stall cycle, then a bubble in EX
      set_load_use(5'd5);
      #1 check("lu_rs1.row", 32'(row), 32'(ROW_LDUSE));
      tick();
      ex_valid = 1'b0;
      #1 check("lu_after.row", 32'(row), 32'(ROW_NORMAL));
      check("lu.stall", 32'(stall_cycles), 32'd1);

      // No stall when the load targets x0 or the source is not read
      set_load_use(5'd0);
      #1 check("lu_x0.row", 32'(row), 32'(ROW_NORMAL));
      set_load_use(5'd5);
      id_rs1_used = 1'b0;
      #1 check("lu_unused.row", 32'(row), 32'(ROW_NORMAL));
      // rs2 match also stalls
      id_rs2 = 5'd5;
      #1 check("lu_rs2.row", 32'(row), 32'(ROW_LDUSE));
      // Invalid decode slot never stalls
      id_valid = 1'b0;
      #1 check("lu_noid.row", 32'(row), 32'(ROW_NORMAL));
      id_valid = 1'b1;
      tick();
      check_regs("lu_rs2", 2'b00, 1'b0, 4'd2, 4'd0);

      // Mispredict beats load-use
      idle_inputs();
      set_load_use(5'd5);
      set_mispred();
      #1 check("mp_lu.row", 32'(row), 32'(ROW_MISPR));
      tick();
      idle_inputs();
      check_regs("mp_lu", 2'b00, 1'b0, 4'd2, 4'd1);

      // Memory stall for 3 cycles with a mispredict pending
      set_mispred();
      mem_req = 1'b1; mem_ready = 1'b0;
      #1 check("ms1.row", 32'(row), 32'(ROW_MSTALL));
      tick();
      check("ms1.state", 32'(state), 32'd1);
      #1 check("ms2.row", 32'(row), 32'(ROW_MSTALL));
      tick();
      check("ms2.state", 32'(state), 32'd1);
      #1 check("ms3.row", 32'(row), 32'(ROW_MSTALL));
      tick();
      check_regs("ms3", 2'b01, 1'b0, 4'd5, 4'd1);
      // Memory completes: the deferred mispredict row now applies
      mem_ready = 1'b1;
      #1 check("ms_done.row", 32'(row), 32'(ROW_MISPR));
      tick();
      idle_inputs();
      check_regs("ms_done", 2'b00, 1'b0, 4'd5, 4'd2);

      // Memory timeout: exactly MEM_TIMEOUT stall cycles, then FAULT
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_regs("pre_tmo", 2'b00, 1'b0, 4'd0, 4'd0);
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 1; i < MEM_TIMEOUT; i++) begin
         tick();
         check("tmo_wait.state", 32'(state), 32'd1);
         check("tmo_wait.tmo", 32'(mem_timeout), 32'd0);
      end
      tick();
      check_regs("tmo", 2'b10, 1'b1, 4'd4, 4'd0);
      // FAULT holds and freezes counters even after the memory answers
      mem_ready = 1'b1;
      set_mispred();
      #1 check("fault.row", 32'(row), 32'(ROW_MSTALL));
      tick();
      tick();
      check_regs("fault_hold", 2'b10, 1'b1, 4'd4, 4'd0);

      // Reset out of FAULT
      reset = 1'b1;
      #1 check("fault_rst.row", 32'(row), 32'(ROW_OFF));
      tick();
      reset = 1'b0;
      idle_inputs();
      check_regs("fault_rst", 2'b00, 1'b0, 4'd0, 4'd0);
      #1 check("post_rst.row", 32'(row), 32'(ROW_NORMAL));

      // Reset mid-wait returns to RUN
      mem_req = 1'b1; mem_ready = 1'b0;
      tick();
      check("midwait.state", 32'(state), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle_inputs();
      check_regs("midwait_rst", 2'b00, 1'b0, 4'd0, 4'd0);

      // 20 load-use stalls saturate a 4-bit counter at 15
      set_load_use(5'd7);
      for (int i = 0; i < 20; i++) tick();
      check("sat.stall", 32'(stall_cycles), 32'd15);
      check("sat.row", 32'(row), 32'(ROW_LDUSE));
      idle_inputs();

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
